// File: rtl/sdes_decrypt_seq.sv
// Multi-cycle S-DES decryptor: accept -> KEY -> RND2 -> RND1 -> DONE; out_valid rises after the 4th edge (accept edge included).
// Ready/valid on both sides; in_ready only in IDLE, and the result is held in DONE until out_ready.
module sdes_decrypt_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:7] ct,
    input  logic [0:9] key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [0:7] pt,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_RND2,
        S_RND1,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [0:7] r_ct;
    logic [0:9] r_key;
    logic [0:7] r_k1;
    logic [0:7] r_k2;
    logic [0:7] r_data;
    logic [0:7] r_pt;

    function automatic logic [0:9] f_p10(input logic [0:9] k);
        return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    endfunction

    // Takes only bits 3..10 of the shifted key, since P8 never selects bits 1-2.
    function automatic logic [0:7] f_p8(input logic [0:7] s);
        return {s[3], s[0], s[4], s[1], s[5], s[2], s[7], s[6]};
    endfunction

    function automatic logic [0:7] f_ip(input logic [0:7] b);
        return {b[1], b[5], b[2], b[0], b[3], b[7], b[4], b[6]};
    endfunction

    function automatic logic [0:7] f_ipinv(input logic [0:7] b);
        return {b[3], b[0], b[2], b[4], b[6], b[1], b[7], b[5]};
    endfunction

    function automatic logic [0:7] f_ep(input logic [0:3] r);
        return {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]};
    endfunction

    function automatic logic [0:3] f_p4(input logic [0:3] s);
        return {s[1], s[3], s[2], s[0]};
    endfunction

    // Table index is {row, col} = {b0, b3, b1, b2}.
    function automatic logic [0:1] f_s0(input logic [0:3] b);
        logic [0:1] v;
        v = 2'd0;
        case ({b[0], b[3], b[1], b[2]})
            4'd0:  v = 2'd1;
            4'd1:  v = 2'd0;
            4'd2:  v = 2'd3;
            4'd3:  v = 2'd2;
            4'd4:  v = 2'd3;
            4'd5:  v = 2'd2;
            4'd6:  v = 2'd1;
            4'd7:  v = 2'd0;
            4'd8:  v = 2'd0;
            4'd9:  v = 2'd2;
            4'd10: v = 2'd1;
            4'd11: v = 2'd3;
            4'd12: v = 2'd3;
            4'd13: v = 2'd1;
            4'd14: v = 2'd3;
            4'd15: v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    function automatic logic [0:1] f_s1(input logic [0:3] b);
        logic [0:1] v;
        v = 2'd0;
        case ({b[0], b[3], b[1], b[2]})
            4'd0:  v = 2'd0;
            4'd1:  v = 2'd1;
            4'd2:  v = 2'd2;
            4'd3:  v = 2'd3;
            4'd4:  v = 2'd2;
            4'd5:  v = 2'd0;
            4'd6:  v = 2'd1;
            4'd7:  v = 2'd3;
            4'd8:  v = 2'd3;
            4'd9:  v = 2'd0;
            4'd10: v = 2'd1;
            4'd11: v = 2'd0;
            4'd12: v = 2'd2;
            4'd13: v = 2'd1;
            4'd14: v = 2'd0;
            4'd15: v = 2'd3;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    // Key schedule from the latched key.
    logic [0:9] w_p10;
    logic [0:9] w_ls1;
    logic [0:9] w_ls2;
    logic [0:7] w_k1;
    logic [0:7] w_k2;

    assign w_p10 = f_p10(r_key);
    assign w_ls1 = {w_p10[1:4], w_p10[0], w_p10[6:9], w_p10[5]};
    assign w_ls2 = {w_ls1[2:4], w_ls1[0:1], w_ls1[7:9], w_ls1[5:6]};
    assign w_k1  = f_p8(w_ls1[2:9]);
    assign w_k2  = f_p8(w_ls2[2:9]);

    // Single fk datapath shared by both rounds; only the subkey is muxed.
    logic [0:7] w_rk;
    logic [0:7] w_x;
    logic [0:1] w_s0;
    logic [0:1] w_s1;
    logic [0:3] w_f;
    logic [0:7] w_fk;

    assign w_rk = (r_state == S_RND1) ? r_k1 : r_k2;
    assign w_x  = f_ep(r_data[4:7]) ^ w_rk;
    assign w_s0 = f_s0(w_x[0:3]);
    assign w_s1 = f_s1(w_x[4:7]);
    assign w_f  = f_p4({w_s0, w_s1});
    assign w_fk = {r_data[0:3] ^ w_f, r_data[4:7]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_KEY;
            S_KEY:   w_next = S_RND2;
            S_RND2:  w_next = S_RND1;
            S_RND1:  w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ct    <= 8'b0;
            r_key   <= 10'b0;
            r_k1    <= 8'b0;
            r_k2    <= 8'b0;
            r_data  <= 8'b0;
            r_pt    <= 8'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ct  <= ct;
                        r_key <= key;
                    end
                end
                S_KEY: begin
                    r_k1   <= w_k1;
                    r_k2   <= w_k2;
                    r_data <= f_ip(r_ct);
                end
                S_RND2:  r_data <= {w_fk[4:7], w_fk[0:3]};
                S_RND1:  r_pt   <= f_ipinv(w_fk);
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign pt        = r_pt;

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Bench for sdes_decrypt_seq: table-driven S-DES model plus a per-cycle protocol/result monitor.
module tb_sdes_decrypt_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:7] ct = 8'h00;
    logic [0:9] key = 10'h000;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [0:7] pt;
    logic       busy;

    sdes_decrypt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- S-DES reference model (1-based position tables) ----------------
    int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int S0_T[16]  = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    int S1_T[16]  = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};
    bit s0_hit[16];
    bit s1_hit[16];

    function automatic int perm(input int v, input int inw, input int n, input int t[10]);
        int r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | ((v >> (inw - t[i])) & 1);
        return r;
    endfunction

    function automatic int rotl5(input int x, input int n);
        return ((x << n) | (x >> (5 - n))) & 31;
    endfunction

    function automatic void sched(input int k, output int k1, output int k2);
        int p, l, r;
        p  = perm(k, 10, 10, P10_T);
        l  = rotl5(p >> 5, 1);
        r  = rotl5(p & 31, 1);
        k1 = perm((l << 5) | r, 10, 8, P8_T);
        k2 = perm((rotl5(l, 2) << 5) | rotl5(r, 2), 10, 8, P8_T);
    endfunction

    function automatic int fk(input int lr, input int k, input bit mark);
        int x, a, b, i0, i1, f;
        x  = perm(lr & 15, 4, 8, EP_T) ^ k;
        a  = x >> 4;
        b  = x & 15;
        i0 = ((((a >> 3) & 1) * 2 + (a & 1)) * 4) + ((a >> 1) & 3);
        i1 = ((((b >> 3) & 1) * 2 + (b & 1)) * 4) + ((b >> 1) & 3);
        if (mark) begin
            s0_hit[i0] = 1'b1;
            s1_hit[i1] = 1'b1;
        end
        f = perm(S0_T[i0] * 4 + S1_T[i1], 4, 4, P4_T);
        return (((lr >> 4) ^ f) << 4) | (lr & 15);
    endfunction

    function automatic int sw(input int t);
        return ((t & 15) << 4) | (t >> 4);
    endfunction

    function automatic int encrypt(input int p, input int k);
        int k1, k2, t;
        sched(k, k1, k2);
        t = fk(perm(p, 8, 8, IP_T), k1, 1'b0);
        t = fk(sw(t), k2, 1'b0);
        return perm(t, 8, 8, IPI_T);
    endfunction

    function automatic int decrypt(input int c, input int k);
        int k1, k2, t;
        sched(k, k1, k2);
        t = fk(perm(c, 8, 8, IP_T), k2, 1'b1);
        t = fk(sw(t), k1, 1'b1);
        return perm(t, 8, 8, IPI_T);
    endfunction

    // ---------------- per-cycle monitor ----------------
    // phase: 0 idle, 1..3 cycles since accept, 4 result pending.
    int phase = 0;
    int exp_q[$];
    bit armed = 1'b0;
    int n_in  = 0;
    int n_out = 0;

    always @(negedge clk) begin
        if (armed) begin
            check("mon_in_ready", in_ready, phase == 0);
            check("mon_busy", busy, phase != 0);
            check("mon_out_valid", out_valid, phase == 4);
            if (phase == 4 && exp_q.size() > 0) check("mon_pt", pt, exp_q[0]);
        end
        if (rst) begin
            phase = 0;
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            case (phase)
                0: if (in_valid) begin
                    exp_q.push_back(decrypt(ct, key));
                    n_in++;
                    phase = 1;
                end
                1, 2, 3: phase++;
                4: if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    phase = 0;
                end
                default: phase = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:7] c, input logic [0:9] k);
        int w = 0;
        ct       = c;
        key      = k;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!out_valid && edges < 50);
        if (!out_valid) check("out_timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    localparam logic [0:9] KEY_A = 10'b1010000010;
    localparam logic [0:7] CT_A  = 8'b00111000;
    localparam logic [0:7] PT_A  = 8'b10010111;

    initial begin
        int e, k1, k2, p, k, c, i0, o0, cnt0, cnt1;
        int acc[8];
        int p_tab[8];
        int k_tab[8];

        // Pin the model against the hand-worked vector.
        sched(KEY_A, k1, k2);
        check("model_k1", k1, 8'b10100100);
        check("model_k2", k2, 8'b01000011);
        check("model_enc", encrypt(PT_A, KEY_A), CT_A);
        check("model_dec", decrypt(CT_A, KEY_A), PT_A);
        for (int i = 0; i < 16; i++) begin
            s0_hit[i] = 1'b0;
            s1_hit[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pt", pt, 0);
        check("rst_k1", dut.r_k1, 0);
        sync();

        // Known vector, latency and internal subkeys.
        out_ready = 1'b1;
        send(CT_A, KEY_A);
        wait_out(e);
        check("lat_edges", e, 3);
        check("vec_pt", pt, PT_A);
        check("vec_k1", dut.r_k1, 8'b10100100);
        check("vec_k2", dut.r_k2, 8'b01000011);
        sync();

        // Output held under backpressure.
        out_ready = 1'b0;
        send(CT_A, KEY_A);
        wait_out(e);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_pt", pt, PT_A);
            check("hold_in_ready", in_ready, 0);
        end
        sync();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        sync();

        // Inputs changing after the accept edge are ignored.
        send(CT_A, KEY_A);
        ct  = 8'hFF;
        key = 10'h3FF;
        wait_out(e);
        check("immune_pt", pt, PT_A);
        sync();

        // Reset during RND2 aborts the operation.
        send(CT_A, KEY_A);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_pt", pt, 0);
        check("abort_in_ready", in_ready, 1);
        sync();
        c = encrypt(8'hA5, 10'h2C7);
        send(c[7:0], 10'h2C7);
        wait_out(e);
        check("after_abort_pt", pt, 8'hA5);
        sync();

        // Back-to-back with in_valid held high.
        for (int i = 0; i < 8; i++) begin
            p_tab[i] = $urandom_range(0, 255);
            k_tab[i] = $urandom_range(0, 1023);
        end
        i0 = n_in;
        o0 = n_out;
        c = encrypt(p_tab[0], k_tab[0]);
        ct  = c[7:0];
        key = k_tab[0][9:0];
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = 0;
            @(negedge clk);
            while (!in_ready && e < 50) begin
                e++;
                @(negedge clk);
            end
            acc[i] = cyc;
            @(posedge clk);
            #1;
            if (i < 7) begin
                c = encrypt(p_tab[i + 1], k_tab[i + 1]);
                ct  = c[7:0];
                key = k_tab[i + 1][9:0];
            end else begin
                in_valid = 1'b0;
            end
        end
        for (int i = 1; i < 8; i++) check("b2b_interval", acc[i] - acc[i - 1], 5);
        repeat (10) sync();
        check("b2b_accepts", n_in - i0, 8);
        check("b2b_results", n_out - o0, 8);

        // Random round trip sweep.
        for (int i = 0; i < 1000; i++) begin
            p = $urandom_range(0, 255);
            k = $urandom_range(0, 1023);
            c = encrypt(p, k);
            send(c[7:0], k[9:0]);
            wait_out(e);
            check("sweep_pt", pt, p);
            sync();
        end
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 16; i++) begin
            cnt0 += s0_hit[i];
            cnt1 += s1_hit[i];
        end
        check("s0_coverage", cnt0, 16);
        check("s1_coverage", cnt1, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
